// File: rtl/ube_pkg.sv
// ----------------------------------------------------------------------------
// ube_pkg
// Shared definitions for the Unibus Exerciser bus-side engine.
//   - UBE_ADDR_W / UBE_DATA_W : Unibus address and data widths
//   - UBE_FLAG_*              : bit positions of the request flags carried in
//                               the upper part of the 36-bit devADDRO word
//   - ubeState_t              : sequencer FSM states
//   - addrStep()              : address increment for byte or word transfers
// ----------------------------------------------------------------------------
package ube_pkg;

  localparam int UBE_ADDR_W = 18;
  localparam int UBE_DATA_W = 16;
  localparam int UBE_BUS_W  = 36;

  localparam int UBE_FLAG_READ  = 18;
  localparam int UBE_FLAG_WRITE = 19;
  localparam int UBE_FLAG_BYTE  = 20;
  localparam int UBE_FLAG_PHYS  = 21;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    GAP,
    FIN
  } ubeState_t;

  // Byte transfers walk the address one byte at a time, word transfers by two.
  function automatic logic [UBE_ADDR_W-1:0] addrStep(input logic byteMode);
    return byteMode ? 18'd1 : 18'd2;
  endfunction

endpackage

// File: rtl/ube_nxm_timer.sv
// ----------------------------------------------------------------------------
// ube_nxm_timer
// Non-existent-memory watchdog for an outstanding NPR request. Only present
// when UBE_NXM_TIMEOUT_EN is defined; without the macro this file is empty.
//   clk     in  clock
//   rst     in  asynchronous reset, active high
//   clear   in  restart the count (new request or UBA init)
//   run     in  count this cycle (request outstanding)
//   expired out the current waiting cycle is the TIMEOUT-th one
// ----------------------------------------------------------------------------
`ifdef UBE_NXM_TIMEOUT_EN
module ube_nxm_timer #(
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  logic [CNT_W-1:0] count;

  // Counts the waiting cycles of the current request; a new request or a
  // UBA init restarts it from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run) begin
      count <= count + 1'b1;
    end
  end

  // The count starts at zero on the first waiting cycle, so TIMEOUT-1 marks
  // the TIMEOUT-th cycle without an acknowledge.
  assign expired = run && (count == CNT_W'(TIMEOUT - 1));

endmodule
`endif

// File: rtl/ube_dma_sequencer.sv
// ----------------------------------------------------------------------------
// ube_dma_sequencer
// Bus-side engine of the Unibus Exerciser. A CSR1 GO strobe raises the
// selected interrupt levels and optionally runs a burst of NPR transfers
// through the UBA, then reports BUSY/DONE/ERR and the last word read.
//
// Optional feature macro: UBE_NXM_TIMEOUT_EN
//   defined   : an unacknowledged request aborts after TIMEOUT waiting cycles
//               with ERR set (non-existent memory)
//   undefined : a request waits for its acknowledge indefinitely, ERR is 0
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   clr              synchronous UBA init, same effect as rst
//   csr1GO           one-cycle GO strobe
//   csr1BR[3:0]      interrupt levels to raise {BR7,BR6,BR5,BR4}
//   csr1NPRS         run an NPR burst on GO
//   csr1NPRO         burst direction, 1 = write memory, 0 = read
//   csr1BYTE         byte transfers (address step 1 instead of 2)
//   dmaADDR/COUNT    burst start address and transfer count, taken at GO
//   dmaDATA          write pattern, taken at the start of each transfer
//   intACK[3:0]      per-level interrupt acknowledge from the UBA
//   devACKI/devDATAI acknowledge and read data for the current request
//   devREQO          NPR request
//   devADDRO         {flags, address} of the current request
//   devDATAO         {20'b0, write pattern} of the current request
//   devINTR[3:0]     pending interrupt levels {7,6,5,4}
//   ubeBUSY/DONE/ERR sequence status
//   ubeRDATA         last word returned by an NPR read
// ----------------------------------------------------------------------------
module ube_dma_sequencer
  import ube_pkg::*;
#(
  parameter int TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  csr1GO,
  input  logic [3:0]            csr1BR,
  input  logic                  csr1NPRS,
  input  logic                  csr1NPRO,
  input  logic                  csr1BYTE,
  input  logic [UBE_ADDR_W-1:0] dmaADDR,
  input  logic [15:0]           dmaCOUNT,
  input  logic [UBE_DATA_W-1:0] dmaDATA,
  input  logic [3:0]            intACK,
  input  logic                  devACKI,
  input  logic [UBE_BUS_W-1:0]  devDATAI,
  output logic                  devREQO,
  output logic [UBE_BUS_W-1:0]  devADDRO,
  output logic [UBE_BUS_W-1:0]  devDATAO,
  output logic [3:0]            devINTR,
  output logic                  ubeBUSY,
  output logic                  ubeDONE,
  output logic                  ubeERR,
  output logic [UBE_DATA_W-1:0] ubeRDATA
);

  ubeState_t             state, nextState;
  logic [UBE_ADDR_W-1:0] addrReg;
  logic [15:0]           countReg;
  logic                  writeDir, byteMode;
  logic [UBE_DATA_W-1:0] dataReg, rdataReg;
  logic [3:0]            intrReg;
  logic                  doneReg;
  logic                  goAccept, xferAck, abortXfer;
  logic                  timerExpired;
  logic [19:0]           unusedDevData;

  assign unusedDevData = devDATAI[35:16];

`ifdef UBE_NXM_TIMEOUT_EN
  logic errReg;

  ube_nxm_timer #(
    .TIMEOUT(TIMEOUT)
  ) uNxmTimer (
    .clk    (clk),
    .rst    (rst),
    .clear  (clr || (state == REQ)),
    .run    (state == WAIT),
    .expired(timerExpired)
  );

  // ERR is sticky from a timeout abort until the next accepted GO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      errReg <= 1'b0;
    end else if (clr) begin
      errReg <= 1'b0;
    end else if (goAccept) begin
      errReg <= 1'b0;
    end else if (abortXfer) begin
      errReg <= 1'b1;
    end
  end

  assign ubeERR = errReg;
`else
  localparam int unusedTimeout = TIMEOUT;

  assign timerExpired = 1'b0;
  assign ubeERR       = 1'b0;
`endif

  // State register; a UBA init drops whatever bus cycle is in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (clr) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state decode. GO is only honoured from IDLE, which is what makes a
  // GO during a burst vanish without latching anything. An acknowledge wins
  // over a timeout arriving in the same cycle.
  always_comb begin
    nextState = state;
    goAccept  = 1'b0;
    xferAck   = 1'b0;
    abortXfer = 1'b0;
    case (state)
      IDLE: begin
        if (csr1GO) begin
          goAccept  = 1'b1;
          nextState = (csr1NPRS && (dmaCOUNT != 16'd0)) ? REQ : FIN;
        end
      end
      REQ: begin
        nextState = WAIT;
      end
      WAIT: begin
        if (devACKI) begin
          xferAck   = 1'b1;
          nextState = (countReg == 16'd1) ? FIN : GAP;
        end else if (timerExpired) begin
          abortXfer = 1'b1;
          nextState = FIN;
        end
      end
      GAP: begin
        nextState = REQ;
      end
      FIN: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Burst datapath: parameters latched at GO, the write pattern taken at the
  // start of every transfer, address/count stepped on each acknowledge and
  // read data captured on the acknowledge cycle. Interrupt levels are set by
  // GO and cleared by intACK, with a same-cycle set taking priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addrReg  <= '0;
      countReg <= '0;
      writeDir <= 1'b0;
      byteMode <= 1'b0;
      dataReg  <= '0;
      rdataReg <= '0;
      intrReg  <= '0;
      doneReg  <= 1'b0;
    end else if (clr) begin
      addrReg  <= '0;
      countReg <= '0;
      writeDir <= 1'b0;
      byteMode <= 1'b0;
      dataReg  <= '0;
      rdataReg <= '0;
      intrReg  <= '0;
      doneReg  <= 1'b0;
    end else begin
      intrReg <= (intrReg & ~intACK) | (goAccept ? csr1BR : 4'b0000);
      if (goAccept) begin
        addrReg  <= dmaADDR;
        countReg <= dmaCOUNT;
        writeDir <= csr1NPRO;
        byteMode <= csr1BYTE;
        doneReg  <= 1'b0;
      end
      if (nextState == REQ) begin
        dataReg <= dmaDATA;
      end
      if (xferAck) begin
        addrReg  <= addrReg + addrStep(byteMode);
        countReg <= countReg - 16'd1;
        if (!writeDir) begin
          rdataReg <= devDATAI[UBE_DATA_W-1:0];
        end
      end
      if (state == FIN) begin
        doneReg <= 1'b1;
      end
    end
  end

  // Request word: flags and address are only driven while a request is up so
  // the bus sees all zeros between transfers.
  always_comb begin
    devADDRO = '0;
    if (devREQO) begin
      devADDRO[UBE_ADDR_W-1:0] = addrReg;
      devADDRO[UBE_FLAG_PHYS]  = 1'b1;
      devADDRO[UBE_FLAG_WRITE] = writeDir;
      devADDRO[UBE_FLAG_READ]  = !writeDir;
      devADDRO[UBE_FLAG_BYTE]  = byteMode;
    end
  end

  assign devREQO  = (state == REQ) || (state == WAIT);
  assign devDATAO = devREQO ? {20'b0, dataReg} : '0;
  assign devINTR  = intrReg;
  assign ubeBUSY  = (state == REQ) || (state == WAIT) || (state == GAP);
  assign ubeDONE  = doneReg;
  assign ubeRDATA = rdataReg;

endmodule
